// File: rtl/mesm6_memory_pkg.sv
// Shared types for the mesm6 memory responder: word/address widths, FSM states, latched request.
package mesm6_memory_pkg;

  localparam int MESM6_WORD_BITS = 48;
  localparam int MESM6_ADDR_BITS = 15;

  typedef logic [MESM6_WORD_BITS-1:0] word_t;
  typedef logic [MESM6_ADDR_BITS-1:0] addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IACC,
    ST_DACC,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic  pend_i;
    logic  pend_d;
    logic  pend_w;
    addr_t iaddr;
    addr_t daddr;
    word_t wdata;
  } req_t;

endpackage

// File: rtl/mesm6_memory_if.sv
// Core-to-memory bundle: instruction fetch bus and data read/write bus.
interface mesm6_memory_if;
  import mesm6_memory_pkg::*;

  logic  ibus_fetch;
  addr_t ibus_addr;
  word_t ibus_input;
  logic  ibus_done;

  logic  dbus_read;
  logic  dbus_write;
  addr_t dbus_addr;
  word_t dbus_output;
  word_t dbus_input;
  logic  dbus_done;

  modport master (
    output ibus_fetch, ibus_addr, dbus_read, dbus_write, dbus_addr, dbus_output,
    input  ibus_input, ibus_done, dbus_input, dbus_done
  );

  modport slave (
    input  ibus_fetch, ibus_addr, dbus_read, dbus_write, dbus_addr, dbus_output,
    output ibus_input, ibus_done, dbus_input, dbus_done
  );

endinterface

// File: rtl/mesm6_ram.sv
// Single-port synchronous RAM, read-first; one-cycle read latency, no backpressure.
module mesm6_ram #(
  parameter int ADDR_BITS = 15,
  parameter int WORD_BITS = 48
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_BITS-1:0] wdata,
  output logic [WORD_BITS-1:0] rdata
);

  logic [WORD_BITS-1:0] mem [0:(2**ADDR_BITS)-1];

  // rdata always returns the word as it was before a same-edge write
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mesm6_memory.sv
// Memory responder serving ibus and dbus from one RAM, fetch slot first then data slot.
// Latency: dones 2 cycles after request (3 with both buses) plus WAIT_STATES per slot; requests held until done.
module mesm6_memory
  import mesm6_memory_pkg::*;
#(
  parameter int ADDR_BITS   = 15,
  parameter int WAIT_STATES = 0,
  parameter bit ZERO_WORD0  = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  mesm6_memory_if.slave bus
);

  state_t               state, state_nxt;
  logic [3:0]           wait_cnt, wait_cnt_nxt;
  logic                 slot_end;
  logic                 latch_req;
  req_t                 req;

  logic [ADDR_BITS-1:0] ram_addr;
  logic                 ram_we;
  word_t                ram_rdata;

  logic                 i_zero, d_zero;
  logic                 cap_i;
  word_t                i_word;

  logic                 ibus_done_q, dbus_done_q;
  word_t                ibus_input_q, dbus_input_q;

  assign slot_end = (wait_cnt == 4'(WAIT_STATES));
  assign i_zero   = ZERO_WORD0 && (req.iaddr[ADDR_BITS-1:0] == '0);
  assign d_zero   = ZERO_WORD0 && (req.daddr[ADDR_BITS-1:0] == '0);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    latch_req    = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = (state == ST_DACC) ? req.daddr[ADDR_BITS-1:0] : req.iaddr[ADDR_BITS-1:0];
    case (state)
      ST_IDLE: begin
        wait_cnt_nxt = '0;
        if (bus.ibus_fetch || bus.dbus_read || bus.dbus_write) begin
          latch_req = 1'b1;
          state_nxt = bus.ibus_fetch ? ST_IACC : ST_DACC;
        end
      end
      ST_IACC: begin
        if (slot_end) begin
          wait_cnt_nxt = '0;
          state_nxt    = req.pend_d ? ST_DACC : ST_DONE;
        end else begin
          wait_cnt_nxt = wait_cnt + 4'd1;
        end
      end
      ST_DACC: begin
        if (slot_end) begin
          wait_cnt_nxt = '0;
          state_nxt    = ST_DONE;
          ram_we       = req.pend_w && !d_zero;
        end else begin
          wait_cnt_nxt = wait_cnt + 4'd1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      req          <= '0;
      cap_i        <= 1'b0;
      i_word       <= '0;
      ibus_done_q  <= 1'b0;
      dbus_done_q  <= 1'b0;
      ibus_input_q <= '0;
      dbus_input_q <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (latch_req) begin
        req.pend_i <= bus.ibus_fetch;
        req.pend_d <= bus.dbus_read | bus.dbus_write;
        req.pend_w <= bus.dbus_write;
        req.iaddr  <= bus.ibus_addr;
        req.daddr  <= bus.dbus_addr;
        req.wdata  <= bus.dbus_output;
      end
      // The fetched word lands on ram_rdata the cycle after the IACC slot ends
      cap_i <= (state == ST_IACC) && slot_end;
      if (cap_i) begin
        i_word <= i_zero ? '0 : ram_rdata;
      end
      ibus_done_q <= (state == ST_DONE) && req.pend_i;
      dbus_done_q <= (state == ST_DONE) && req.pend_d;
      if (state == ST_DONE) begin
        if (req.pend_i) begin
          if (cap_i) begin
            ibus_input_q <= i_zero ? '0 : ram_rdata;
          end else begin
            ibus_input_q <= i_word;
          end
        end
        if (req.pend_d) begin
          dbus_input_q <= d_zero ? '0 : ram_rdata;
        end
      end
    end
  end

  assign bus.ibus_done  = ibus_done_q;
  assign bus.dbus_done  = dbus_done_q;
  assign bus.ibus_input = ibus_input_q;
  assign bus.dbus_input = dbus_input_q;

  mesm6_ram #(
    .ADDR_BITS (ADDR_BITS),
    .WORD_BITS (MESM6_WORD_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (req.wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mesm6_memory.sv
// Bench for mesm6_memory: vector table on a zero-wait instance, hand sequences for wait states and reset.
module tb_mesm6_memory;
  import mesm6_memory_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst2, rst3;

  mesm6_memory_if m0 ();
  mesm6_memory_if m2 ();
  mesm6_memory_if m3 ();

  mesm6_memory #(.WAIT_STATES(0)) u0 (.clk(clk), .reset(rst0), .bus(m0));
  mesm6_memory #(.WAIT_STATES(2)) u2 (.clk(clk), .reset(rst2), .bus(m2));
  mesm6_memory #(.WAIT_STATES(3)) u3 (.clk(clk), .reset(rst3), .bus(m3));

  typedef struct {
    logic  f, r, w;
    addr_t ia, da;
    word_t wd;
    logic  e_id, e_dd;
    word_t e_iin, e_din;
    logic  chk_din;
    int    e_lat;
  } vec_t;

  typedef struct {
    logic  idone, ddone;
    word_t iin, din;
  } obs_t;

  localparam word_t W5  = 48'h123456789ABC;
  localparam word_t W7  = 48'hFFFF00000001;
  localparam word_t W7B = 48'h000000000042;
  localparam word_t W6  = 48'h600000000006;
  localparam word_t W3  = 48'h333333333333;
  localparam word_t W4  = 48'h444444444444;
  localparam word_t W9A = 48'h9A9A9A9A9A9A;
  localparam word_t W9B = 48'h0B0B0B0B0B0B;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic f, input logic r, input logic w,
                       input addr_t ia, input addr_t da, input word_t wd);
    case (sel)
      0: begin
        m0.ibus_fetch = f; m0.dbus_read = r; m0.dbus_write = w;
        m0.ibus_addr = ia; m0.dbus_addr = da; m0.dbus_output = wd;
      end
      2: begin
        m2.ibus_fetch = f; m2.dbus_read = r; m2.dbus_write = w;
        m2.ibus_addr = ia; m2.dbus_addr = da; m2.dbus_output = wd;
      end
      default: begin
        m3.ibus_fetch = f; m3.dbus_read = r; m3.dbus_write = w;
        m3.ibus_addr = ia; m3.dbus_addr = da; m3.dbus_output = wd;
      end
    endcase
  endtask

  function automatic obs_t sample(input int sel);
    obs_t o;
    case (sel)
      0:       o = '{m0.ibus_done, m0.dbus_done, m0.ibus_input, m0.dbus_input};
      2:       o = '{m2.ibus_done, m2.dbus_done, m2.ibus_input, m2.dbus_input};
      default: o = '{m3.ibus_done, m3.dbus_done, m3.ibus_input, m3.dbus_input};
    endcase
    return o;
  endfunction

  function automatic vec_t mk(input logic f, input logic r, input logic w,
                              input addr_t ia, input addr_t da, input word_t wd,
                              input word_t e_iin, input word_t e_din, input logic chk_din,
                              input int e_lat);
    vec_t v;
    v = '{f, r, w, ia, da, wd, f, r | w, e_iin, e_din, chk_din, e_lat};
    return v;
  endfunction

  // Called at a negedge; lat k means done seen in the cycle after edge E_k (E0 samples the request)
  task automatic run_txn(input int sel, input string tag, input vec_t v);
    obs_t o;
    int   lat;
    lat = -1;
    o   = sample(sel);
    drive(sel, v.f, v.r, v.w, v.ia, v.da, v.wd);
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      o = sample(sel);
      if (o.idone || o.ddone) begin
        lat = k;
        break;
      end
    end
    drive(sel, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    check($sformatf("%s latency", tag), 64'(lat), 64'(v.e_lat));
    check($sformatf("%s ibus_done", tag), 64'(o.idone), 64'(v.e_id));
    check($sformatf("%s dbus_done", tag), 64'(o.ddone), 64'(v.e_dd));
    if (v.e_id) check($sformatf("%s ibus_input", tag), 64'(o.iin), 64'(v.e_iin));
    if (v.chk_din) check($sformatf("%s dbus_input", tag), 64'(o.din), 64'(v.e_din));
    @(negedge clk);
    o = sample(sel);
    check($sformatf("%s single pulse", tag), {62'd0, o.idone, o.ddone}, 64'd0);
  endtask

  vec_t vecs [13];

  initial begin
    obs_t o;

    vecs[0]  = mk(0, 0, 1, 15'd0, 15'd5, W5,  '0,  '0,  0, 2);
    vecs[1]  = mk(1, 0, 0, 15'd5, 15'd0, '0,  W5,  '0,  0, 2);
    vecs[2]  = mk(0, 0, 1, 15'd0, 15'd7, W7,  '0,  '0,  0, 2);
    vecs[3]  = mk(0, 1, 0, 15'd0, 15'd7, '0,  '0,  W7,  1, 2);
    vecs[4]  = mk(0, 1, 1, 15'd0, 15'd7, W7B, '0,  W7,  1, 2);
    vecs[5]  = mk(0, 1, 0, 15'd0, 15'd7, '0,  '0,  W7B, 1, 2);
    vecs[6]  = mk(0, 0, 1, 15'd0, 15'd0, 48'hAAAA, '0, '0, 0, 2);
    vecs[7]  = mk(1, 0, 0, 15'd0, 15'd0, '0,  '0,  '0,  0, 2);
    vecs[8]  = mk(0, 1, 0, 15'd0, 15'd0, '0,  '0,  '0,  1, 2);
    vecs[9]  = mk(1, 1, 0, 15'd5, 15'd7, '0,  W5,  W7B, 1, 3);
    vecs[10] = mk(1, 0, 1, 15'd5, 15'd6, W6,  W5,  '0,  0, 3);
    vecs[11] = mk(1, 0, 0, 15'd6, 15'd0, '0,  W6,  '0,  0, 2);
    vecs[12] = mk(1, 1, 0, 15'd5, 15'd6, '0,  W5,  W6,  1, 3);

    rst0 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    drive(0, 0, 0, 0, '0, '0, '0);
    drive(2, 0, 0, 0, '0, '0, '0);
    drive(3, 0, 0, 0, '0, '0, '0);
    repeat (3) @(negedge clk);
    o = sample(0);
    check("reset ibus_done", 64'(o.idone), 64'd0);
    check("reset dbus_done", 64'(o.ddone), 64'd0);
    check("reset ibus_input", 64'(o.iin), 64'd0);
    check("reset dbus_input", 64'(o.din), 64'd0);
    rst0 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      run_txn(0, $sformatf("vec%0d", i), vecs[i]);
    end

    // Reset held with a fetch pending: outputs clear, then the fetch is served afterwards
    rst0 = 1'b1;
    drive(0, 1, 0, 0, 15'd5, '0, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      o = sample(0);
      check($sformatf("rst hold%0d dones", c), {62'd0, o.idone, o.ddone}, 64'd0);
      check($sformatf("rst hold%0d data", c), {o.iin[31:0], o.din[31:0]}, 64'd0);
    end
    rst0 = 1'b0;
    run_txn(0, "post_reset_fetch", mk(1, 0, 0, 15'd5, '0, '0, W5, '0, 0, 2));

    // Two wait states, both buses at once
    run_txn(2, "ws2_wr3", mk(0, 0, 1, '0, 15'd3, W3, '0, '0, 0, 4));
    run_txn(2, "ws2_wr4", mk(0, 0, 1, '0, 15'd4, W4, '0, '0, 0, 4));
    run_txn(2, "ws2_both", mk(1, 1, 0, 15'd3, 15'd4, '0, W3, W4, 1, 7));

    // Three wait states: reset lands in DACC before the commit cycle
    run_txn(3, "ws3_wr9", mk(0, 0, 1, '0, 15'd9, W9A, '0, '0, 0, 5));
    drive(3, 0, 0, 1, '0, 15'd9, W9B);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst3 = 1'b1;
    drive(3, 0, 0, 0, '0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      o = sample(3);
      check($sformatf("ws3 abort%0d dbus_done", c), 64'(o.ddone), 64'd0);
    end
    check("ws3 abort dbus_input", 64'(o.din), 64'd0);
    rst3 = 1'b0;
    @(negedge clk);
    run_txn(3, "ws3_rd9", mk(0, 1, 0, '0, 15'd9, '0, '0, W9A, 1, 5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
